// File: rtl/note_key_scheduler_if.sv
// Signal bundle between the keyboard/oscillator side (master) and note_key_scheduler (slave).
// The master drives keys and wave_edge. The slave returns the note, gate and half-period outputs.
interface note_key_scheduler_if;
    logic [11:0] key;
    logic        wave_edge;
    logic [7:0]  current_half_period;
    logic        gate;
    logic [3:0]  note_idx;
    logic        period_update;
    logic        test_LED_R;

    modport master (
        output key, wave_edge,
        input  current_half_period, gate, note_idx, period_update, test_LED_R
    );

    modport slave (
        input  key, wave_edge,
        output current_half_period, gate, note_idx, period_update, test_LED_R
    );
endinterface

// File: rtl/note_key_scheduler.sv
// Monophonic last-note-priority key scheduler for a square-wave oscillator.
// Pitch changes and note-off are applied only on wave_edge (or after a timeout) so no half-cycle is truncated.
module note_key_scheduler #(
    parameter int DEBOUNCE_CYCLES = 61440,
    parameter int EDGE_TIMEOUT    = 32768
) (
    input logic                  clk,
    input logic                  rst,
    note_key_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, PLAYING, PENDING, RELEASING} state_t;

    localparam int TICK_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMO_W  = (EDGE_TIMEOUT > 1) ? $clog2(EDGE_TIMEOUT) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(EDGE_TIMEOUT - 1);

    function automatic logic [3:0] lowest_idx(input logic [11:0] v);
        lowest_idx = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (v[i]) lowest_idx = 4'(i + 1);
        end
    endfunction

    function automatic logic [7:0] half_period(input logic [3:0] idx);
        case (idx)
            4'd1:    half_period = 8'd92;
            4'd2:    half_period = 8'd87;
            4'd3:    half_period = 8'd82;
            4'd4:    half_period = 8'd77;
            4'd5:    half_period = 8'd73;
            4'd6:    half_period = 8'd69;
            4'd7:    half_period = 8'd65;
            4'd8:    half_period = 8'd61;
            4'd9:    half_period = 8'd58;
            4'd10:   half_period = 8'd55;
            4'd11:   half_period = 8'd51;
            4'd12:   half_period = 8'd49;
            default: half_period = 8'd0;
        endcase
    endfunction

    // Input path: synchroniser, sample tick, debouncer, arbiter.
    logic [11:0]       key_s1_q, key_s1_d, key_s2_q, key_s2_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick_dly_q, tick_dly_d;
    logic [11:0]       samp_q, samp_d, samp_prev_q, samp_prev_d;
    logic [11:0]       deb_q, deb_d, deb_last_q, deb_last_d;
    logic [3:0]        cand_q, cand_d;
    logic              tick;
    logic [11:0]       rising;
    logic [12:0]       deb_ext;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        key_s1_d    = bus.key;
        key_s2_d    = key_s1_q;
        tick        = (tick_cnt_q == TICK_LAST);
        tick_cnt_d  = tick ? '0 : tick_cnt_q + TICK_W'(1);
        tick_dly_d  = tick;
        samp_d      = tick ? key_s2_q : samp_q;
        samp_prev_d = tick ? samp_q : samp_prev_q;
        deb_d       = deb_q;
        if (tick_dly_q) begin
            // Agreeing samples set the level; disagreeing samples keep the old one.
            deb_d = (samp_q & samp_prev_q) | (deb_q & (samp_q | samp_prev_q));
        end
        deb_last_d = deb_q;
        rising     = deb_q & ~deb_last_q;
        deb_ext    = {deb_q, 1'b0};
        cand_d     = cand_q;
        if (rising != 12'd0) begin
            cand_d = lowest_idx(rising);
        end else if (deb_q == 12'd0) begin
            cand_d = 4'd0;
        end else if (!deb_ext[cand_q]) begin
            cand_d = lowest_idx(deb_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s1_q    <= '0;
            key_s2_q    <= '0;
            tick_cnt_q  <= '0;
            tick_dly_q  <= 1'b0;
            samp_q      <= '0;
            samp_prev_q <= '0;
            deb_q       <= '0;
            deb_last_q  <= '0;
            cand_q      <= '0;
        end else begin
            key_s1_q    <= key_s1_d;
            key_s2_q    <= key_s2_d;
            tick_cnt_q  <= tick_cnt_d;
            tick_dly_q  <= tick_dly_d;
            samp_q      <= samp_d;
            samp_prev_q <= samp_prev_d;
            deb_q       <= deb_d;
            deb_last_q  <= deb_last_d;
            cand_q      <= cand_d;
        end
    end

    // Output sequencer.
    state_t           state_q;
    logic [3:0]       note_q;
    logic [7:0]       period_q;
    logic             gate_q, upd_q, led_q;
    logic [TMO_W-1:0] tmo_q;
    logic             fire;

    assign fire = bus.wave_edge || (tmo_q == TMO_LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            note_q   <= 4'd0;
            period_q <= 8'd0;
            gate_q   <= 1'b0;
            upd_q    <= 1'b0;
            led_q    <= 1'b1;
            tmo_q    <= '0;
        end else begin
            upd_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cand_q != 4'd0) begin
                        note_q   <= cand_q;
                        period_q <= half_period(cand_q);
                        gate_q   <= 1'b1;
                        led_q    <= 1'b0;
                        upd_q    <= 1'b1;
                        state_q  <= PLAYING;
                    end
                end
                PLAYING: begin
                    if (cand_q == 4'd0) begin
                        state_q <= RELEASING;
                        tmo_q   <= '0;
                    end else if (cand_q != note_q) begin
                        state_q <= PENDING;
                        tmo_q   <= '0;
                    end
                end
                PENDING: begin
                    if (cand_q == note_q) begin
                        state_q <= PLAYING;
                    end else if (fire) begin
                        // The edge is consumed by whatever cand holds now, including a release.
                        note_q   <= cand_q;
                        period_q <= half_period(cand_q);
                        gate_q   <= (cand_q != 4'd0);
                        led_q    <= (cand_q == 4'd0);
                        upd_q    <= 1'b1;
                        state_q  <= (cand_q == 4'd0) ? IDLE : PLAYING;
                    end else if (cand_q == 4'd0) begin
                        state_q <= RELEASING;
                        tmo_q   <= '0;
                    end else if (tmo_q != TMO_LAST) begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                RELEASING: begin
                    if (cand_q == note_q) begin
                        state_q <= PLAYING;
                    end else if (fire) begin
                        note_q   <= 4'd0;
                        period_q <= 8'd0;
                        gate_q   <= 1'b0;
                        led_q    <= 1'b1;
                        upd_q    <= 1'b1;
                        state_q  <= IDLE;
                    end else if (cand_q != 4'd0) begin
                        state_q <= PENDING;
                        tmo_q   <= '0;
                    end else if (tmo_q != TMO_LAST) begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.current_half_period = period_q;
    assign bus.gate                = gate_q;
    assign bus.note_idx            = note_q;
    assign bus.period_update       = upd_q;
    assign bus.test_LED_R          = led_q;

endmodule

// File: tb/tb_note_key_scheduler.sv
// Bench for note_key_scheduler: directed scenarios plus randomized key sequences
// checked against a last-note-priority reference model and output invariants.
module tb_note_key_scheduler;

    localparam int DEB = 8;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst;

    note_key_scheduler_if ifc();

    note_key_scheduler #(.DEBOUNCE_CYCLES(DEB), .EDGE_TIMEOUT(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int half_tbl [13] = '{0, 92, 87, 82, 77, 73, 69, 65, 61, 58, 55, 51, 49};

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; returns on the negedge after the sampling clock edge.
    task automatic pulse_edge();
        ifc.wave_edge = 1'b1;
        @(negedge clk);
        ifc.wave_edge = 1'b0;
    endtask

    function automatic int first_set(input logic [11:0] v);
        for (int i = 0; i < 12; i++) begin
            if (v[i]) return i + 1;
        end
        return 0;
    endfunction

    // Last-note priority: newest press wins, lowest index breaks ties, fall back to lowest held.
    function automatic int model_cand(input int cur, input logic [11:0] oldv, input logic [11:0] newv);
        logic [11:0] rise;
        rise = newv & ~oldv;
        if (rise != 12'd0) return first_set(rise);
        if (newv == 12'd0) return 0;
        if (cur == 0 || !newv[cur-1]) return first_set(newv);
        return cur;
    endfunction

    task automatic settle_off();
        int n;
        n = 0;
        ifc.key = '0;
        while (ifc.gate !== 1'b0 && n < 300) begin
            if (n % 10 == 9) pulse_edge();
            else @(negedge clk);
            n++;
        end
        checks++;
        if (ifc.gate !== 1'b0) begin
            failures++;
            $display("FAIL settle_off: gate=%0b after %0d cycles, required 0", ifc.gate, n);
        end
        cycles(40);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.key = '0;
        ifc.wave_edge = 1'b0;
        cycles(3);
        rst = 1'b0;
        cycles(2);
        checks++;
        if ({ifc.current_half_period, ifc.gate, ifc.note_idx, ifc.period_update, ifc.test_LED_R} !== {8'd0, 1'b0, 4'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state: period=%0d gate=%0b note=%0d upd=%0b led=%0b, required 0 0 0 0 1",
                     ifc.current_half_period, ifc.gate, ifc.note_idx, ifc.period_update, ifc.test_LED_R);
        end
    endtask

    task automatic test_single_press();
        int pulses;
        pulses = 0;
        ifc.key = 12'h001;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ifc.period_update === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL press_update_count: got %0d pulses, required 1", pulses);
        end
        checks++;
        if ({ifc.gate, ifc.note_idx, ifc.current_half_period, ifc.test_LED_R} !== {1'b1, 4'd1, 8'd92, 1'b0}) begin
            failures++;
            $display("FAIL press_c4: gate=%0b note=%0d period=%0d led=%0b, required 1 1 92 0",
                     ifc.gate, ifc.note_idx, ifc.current_half_period, ifc.test_LED_R);
        end
        settle_off();
    endtask

    task automatic test_glitch();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            ifc.key = (i % 5 == 0) ? 12'h001 : 12'h000;
            @(negedge clk);
            if (ifc.period_update === 1'b1) pulses++;
        end
        ifc.key = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ifc.period_update === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || ifc.gate !== 1'b0 || ifc.note_idx !== 4'd0) begin
            failures++;
            $display("FAIL glitch_ignored: upd pulses=%0d gate=%0b note=%0d, required 0 0 0",
                     pulses, ifc.gate, ifc.note_idx);
        end
        ifc.key = 12'h200;
        cycles(40);
        pulse_edge();
        checks++;
        if (ifc.note_idx !== 4'd10 || ifc.current_half_period !== 8'd55) begin
            failures++;
            $display("FAIL glitch_then_a4: note=%0d period=%0d, required 10 55", ifc.note_idx, ifc.current_half_period);
        end
        settle_off();
    endtask

    task automatic test_fallback();
        ifc.key = 12'h001;
        cycles(40);
        pulse_edge();
        checks++;
        if (ifc.period_update !== 1'b0 || ifc.current_half_period !== 8'd92) begin
            failures++;
            $display("FAIL edge_in_playing: upd=%0b period=%0d, required 0 92", ifc.period_update, ifc.current_half_period);
        end
        ifc.key = 12'h011;
        cycles(40);
        checks++;
        if (ifc.note_idx !== 4'd1 || ifc.current_half_period !== 8'd92) begin
            failures++;
            $display("FAIL wait_for_edge: note=%0d period=%0d, required 1 92", ifc.note_idx, ifc.current_half_period);
        end
        pulse_edge();
        checks++;
        if ({ifc.note_idx, ifc.current_half_period, ifc.period_update} !== {4'd5, 8'd73, 1'b1}) begin
            failures++;
            $display("FAIL retarget_at_edge: note=%0d period=%0d upd=%0b, required 5 73 1",
                     ifc.note_idx, ifc.current_half_period, ifc.period_update);
        end
        cycles(1);
        checks++;
        if (ifc.period_update !== 1'b0) begin
            failures++;
            $display("FAIL update_one_cycle: upd=%0b, required 0", ifc.period_update);
        end
        ifc.key = 12'h001;
        cycles(40);
        checks++;
        if (ifc.current_half_period !== 8'd73) begin
            failures++;
            $display("FAIL fallback_wait: period=%0d, required 73", ifc.current_half_period);
        end
        pulse_edge();
        checks++;
        if ({ifc.note_idx, ifc.current_half_period, ifc.period_update} !== {4'd1, 8'd92, 1'b1}) begin
            failures++;
            $display("FAIL fallback_at_edge: note=%0d period=%0d upd=%0b, required 1 92 1",
                     ifc.note_idx, ifc.current_half_period, ifc.period_update);
        end
    endtask

    // Continues from a sounding C4; releases with no wave_edge at all.
    task automatic test_timeout();
        int lat;
        lat = 0;
        ifc.key = '0;
        while (ifc.gate === 1'b1 && lat < 150) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat < 66 || lat > 90) begin
            failures++;
            $display("FAIL timeout_latency: gate fell after %0d cycles, required 66..90", lat);
        end
        checks++;
        if ({ifc.gate, ifc.note_idx, ifc.current_half_period, ifc.period_update, ifc.test_LED_R} !== {1'b0, 4'd0, 8'd0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL timeout_release: gate=%0b note=%0d period=%0d upd=%0b led=%0b, required 0 0 0 1 1",
                     ifc.gate, ifc.note_idx, ifc.current_half_period, ifc.period_update, ifc.test_LED_R);
        end
        cycles(40);
    endtask

    task automatic test_chord();
        ifc.key = 12'h084;
        cycles(40);
        checks++;
        if (ifc.note_idx !== 4'd3 || ifc.current_half_period !== 8'd82) begin
            failures++;
            $display("FAIL chord_lowest: note=%0d period=%0d, required 3 82", ifc.note_idx, ifc.current_half_period);
        end
    endtask

    // Continues from the sounding chord; resets while waiting for the release edge.
    task automatic test_reset_releasing();
        ifc.key = '0;
        cycles(35);
        checks++;
        if (ifc.gate !== 1'b1) begin
            failures++;
            $display("FAIL releasing_holds_gate: gate=%0b, required 1", ifc.gate);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ifc.gate, ifc.note_idx, ifc.current_half_period, ifc.period_update, ifc.test_LED_R} !== {1'b0, 4'd0, 8'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL async_reset: gate=%0b note=%0d period=%0d upd=%0b led=%0b, required 0 0 0 0 1",
                     ifc.gate, ifc.note_idx, ifc.current_half_period, ifc.period_update, ifc.test_LED_R);
        end
        cycles(3);
        rst = 1'b0;
        cycles(2);
    endtask

    task automatic test_random();
        logic [11:0] prev_keys, new_keys;
        int exp_note, last_note, since_edge, note, exp_p;
        logic e;
        prev_keys  = '0;
        exp_note   = 0;
        last_note  = 0;
        since_edge = 100;
        for (int it = 0; it < 25; it++) begin
            case ($urandom_range(0, 3))
                0:       new_keys = prev_keys ^ (12'd1 << $urandom_range(0, 11));
                1:       new_keys = 12'($urandom) & 12'($urandom) & 12'($urandom);
                2:       new_keys = '0;
                default: new_keys = prev_keys | (12'd1 << $urandom_range(0, 11));
            endcase
            exp_note  = model_cand(exp_note, prev_keys, new_keys);
            prev_keys = new_keys;
            ifc.key   = new_keys;
            for (int c = 0; c < 120; c++) begin
                e = (c < 110) && ($urandom_range(0, 15) == 0);
                ifc.wave_edge = e;
                @(negedge clk);
                since_edge = e ? 0 : since_edge + 1;
                note  = int'(ifc.note_idx);
                exp_p = (note <= 12) ? half_tbl[note] : -1;
                checks++;
                if (int'(ifc.current_half_period) !== exp_p || ifc.gate !== (note != 0) ||
                    ifc.test_LED_R !== (note == 0) || ifc.period_update !== (note != last_note)) begin
                    failures++;
                    $display("FAIL rand_invariant it=%0d c=%0d: note=%0d period=%0d gate=%0b led=%0b upd=%0b, required period=%0d gate=%0b led=%0b upd=%0b",
                             it, c, note, ifc.current_half_period, ifc.gate, ifc.test_LED_R, ifc.period_update,
                             exp_p, note != 0, note == 0, note != last_note);
                end
                if (note != last_note && last_note != 0) begin
                    checks++;
                    if (!(e || since_edge >= TMO - 1)) begin
                        failures++;
                        $display("FAIL rand_edge_align it=%0d c=%0d: note %0d->%0d with last edge %0d cycles ago, required edge or >=%0d",
                                 it, c, last_note, note, since_edge, TMO - 1);
                    end
                end
                last_note = note;
            end
            checks++;
            if (int'(ifc.note_idx) !== exp_note || int'(ifc.current_half_period) !== half_tbl[exp_note]) begin
                failures++;
                $display("FAIL rand_settled it=%0d keys=%03h: note=%0d period=%0d, required %0d %0d",
                         it, new_keys, ifc.note_idx, ifc.current_half_period, exp_note, half_tbl[exp_note]);
            end
        end
        ifc.wave_edge = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_fallback();
        test_timeout();
        test_chord();
        test_reset_releasing();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
